// File: rtl/embedded_soc_debug_ocimem_seq_pkg.sv
// Shared definitions for the debug-memory command sequencer: FSM states,
// jdo field positions and the read-timeout data pattern.
package embedded_soc_debug_ocimem_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_CMD  = 2'd1,
    S_RD_WAIT = 2'd2,
    S_WR_CMD  = 2'd3
  } ocimem_state_t;

  localparam int ADDR_LSB    = 17;
  localparam int RD_FLAG     = 34;
  localparam int ERRCLR_FLAG = 33;
  localparam int WDATA_LSB   = 3;

  localparam logic [31:0] TIMEOUT_PATTERN = 32'hDEAD_BEEF;

endpackage

// File: rtl/embedded_soc_debug_ocimem_seq.sv
// Turns decoded JTAG debug commands into single-word reads/writes on the
// debug-memory master port and reports data/status back to the TCK side.
module embedded_soc_debug_ocimem_seq
  import embedded_soc_debug_ocimem_seq_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  ocimem_state_t     state, state_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic [31:0]       wdata, wdata_nxt;
  logic [31:0]       mon, mon_nxt;
  logic              err, err_nxt;
  logic [15:0]       timer, timer_nxt;
  logic [15:0]       tick;
  logic              cmd_any;
  logic              unused_jdo;

  assign unused_jdo = ^{jdo[37:35], jdo[2:0]};
  assign cmd_any    = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign tick       = timer + 16'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      addr  <= '0;
      wdata <= '0;
      mon   <= '0;
      err   <= 1'b0;
      timer <= '0;
    end else begin
      state <= state_nxt;
      addr  <= addr_nxt;
      wdata <= wdata_nxt;
      mon   <= mon_nxt;
      err   <= err_nxt;
      timer <= timer_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    wdata_nxt = wdata;
    mon_nxt   = mon;
    err_nxt   = err;
    timer_nxt = timer;
    unique case (state)
      S_IDLE: begin
        if (take_action_ocimem_a) begin
          addr_nxt = jdo[ADDR_LSB +: ADDR_W];
          if (jdo[ERRCLR_FLAG]) err_nxt = 1'b0;
          if (jdo[RD_FLAG])     state_nxt = S_RD_CMD;
        end else if (take_action_ocimem_b) begin
          wdata_nxt = jdo[WDATA_LSB +: 32];
          state_nxt = S_WR_CMD;
        end else if (take_no_action_ocimem_a) begin
          state_nxt = S_RD_CMD;
        end
      end
      S_RD_CMD: begin
        if (!avm_waitrequest) begin
          state_nxt = S_RD_WAIT;
          timer_nxt = '0;
        end
      end
      S_RD_WAIT: begin
        if (avm_readdatavalid) begin
          mon_nxt   = avm_readdata;
          addr_nxt  = addr + ADDR_W'(1);
          state_nxt = S_IDLE;
        end else if (tick == 16'(TIMEOUT)) begin
          // Give up: flag the error and leave addr pointing at the failed word
          mon_nxt   = TIMEOUT_PATTERN;
          err_nxt   = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          timer_nxt = tick;
        end
      end
      S_WR_CMD: begin
        if (!avm_waitrequest) begin
          addr_nxt  = addr + ADDR_W'(1);
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    // Commands arriving while busy are dropped, but the host must hear about it
    if (state != S_IDLE && cmd_any) err_nxt = 1'b1;
  end

  assign avm_address   = addr;
  assign avm_read      = (state == S_RD_CMD);
  assign avm_write     = (state == S_WR_CMD);
  assign avm_writedata = wdata;
  assign MonDReg       = mon;
  assign monitor_ready = (state == S_IDLE);
  assign monitor_error = err;

endmodule
